// File: rtl/phrase_pkg.sv
// Shared types and constants for the phrase playback engine.
package phrase_pkg;

  localparam int NUM_CH = 4;
  localparam int ROW_W  = 4;
  // Row-length counter: max(speed,1) up to 31 plus swing up to 15.
  localparam int TCNT_W = 6;

  localparam logic [7:0] NOTE_EMPTY = 8'h00;
  localparam logic [7:0] NOTE_OFF   = 8'hFF;

  typedef struct packed {
    logic [7:0] note;
    logic [5:0] volume;
    logic [1:0] instrument;
  } phrase_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/tick_divider.sv
// Tempo tick generator: one-cycle tick every TICK_DIV clocks, restartable
// with clear so the first tick lands TICK_DIV cycles after playback starts.
module tick_divider #(
  parameter int TICK_DIV = 1666667
) (
  input  logic clk,
  input  logic rst_active_high,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running modulo-TICK_DIV counter, zeroed by reset or clear.
  always_ff @(posedge clk) begin
    if (rst_active_high || clear) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST) && !clear;

endmodule

// File: rtl/phrase_sequencer.sv
// Phrase playback engine: steps through the 16-row phrase memory at a tempo
// derived from clk and converts each row's channel words into per-channel
// note events (trig/gate plus latched note, volume, instrument).
// Optional build macro: SEQ_SWING_EN adds a swing[3:0] input that lengthens
// even rows by swing ticks.
module phrase_sequencer #(
  parameter int TICK_DIV = 1666667,
  parameter int ROWS     = 16
) (
  input  logic        clk,
  input  logic        rst_active_high,
  input  logic        play,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [4:0]  speed,
`ifdef SEQ_SWING_EN
  input  logic [3:0]  swing,
`endif
  output logic [3:0]  row,
  input  logic [15:0] channel_0,
  input  logic [15:0] channel_1,
  input  logic [15:0] channel_2,
  input  logic [15:0] channel_3,
  output logic [31:0] note_out,
  output logic [23:0] vol_out,
  output logic [7:0]  inst_out,
  output logic [3:0]  gate,
  output logic [3:0]  trig,
  output logic        row_strobe,
  output logic        playing,
  output logic        phrase_done
);

  import phrase_pkg::*;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  // Row length in ticks: speed 0 behaves as 1, plus any extra swing ticks.
  function automatic logic [TCNT_W-1:0] row_ticks(input logic [4:0] spd,
                                                  input logic [3:0] extra);
    logic [TCNT_W-1:0] base;
    base = (spd == 5'd0) ? TCNT_W'(1) : TCNT_W'(spd);
    return base + TCNT_W'(extra);
  endfunction

  seq_state_t          state;
  seq_state_t          state_nxt;
  logic                tick;
  logic                div_clear;
  logic                last_tick;
  logic [3:0]          swing_add;
  logic [TCNT_W-1:0]   tick_cnt;
  logic [TCNT_W-1:0]   row_len;
  phrase_entry_t       ent [NUM_CH];

  assign ent[0] = channel_0;
  assign ent[1] = channel_1;
  assign ent[2] = channel_2;
  assign ent[3] = channel_3;

`ifdef SEQ_SWING_EN
  assign swing_add = row[0] ? 4'd0 : swing;
`else
  assign swing_add = 4'd0;
`endif

  // The tempo grid restarts on every play so row 0 always gets a full tick.
  assign div_clear = play;
  assign row_len   = row_ticks(speed, swing_add);
  assign last_tick = (state == HOLD) && tick && ((tick_cnt + TCNT_W'(1)) >= row_len);

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .clear           (div_clear),
    .tick            (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: stop beats play, play beats everything else.
  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (play) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        IDLE:  state_nxt = IDLE;
        FETCH: state_nxt = HOLD;
        HOLD: begin
          if (last_tick) begin
            if ((row == LAST_ROW) && !loop_en) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = FETCH;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic decoded from the state register.
  always_comb begin
    playing = (state != IDLE);
  end

  // Row pointer, tick counter, entry evaluation and event pulses.
  always_ff @(posedge clk) begin
    trig        <= '0;
    row_strobe  <= 1'b0;
    phrase_done <= 1'b0;
    if (rst_active_high) begin
      row      <= '0;
      tick_cnt <= '0;
      note_out <= '0;
      vol_out  <= '0;
      inst_out <= '0;
      gate     <= '0;
    end else if (stop) begin
      row      <= '0;
      tick_cnt <= '0;
      gate     <= '0;
    end else if (play) begin
      // Restart: gates are left alone until row 0 is evaluated.
      row      <= '0;
      tick_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          row <= '0;
        end
        FETCH: begin
          row_strobe <= 1'b1;
          tick_cnt   <= '0;
          for (int c = 0; c < NUM_CH; c++) begin
            if (ent[c].note == NOTE_OFF) begin
              gate[c] <= 1'b0;
            end else if (ent[c].note != NOTE_EMPTY) begin
              note_out[8*c +: 8] <= ent[c].note;
              vol_out[6*c +: 6]  <= ent[c].volume;
              inst_out[2*c +: 2] <= ent[c].instrument;
              gate[c]            <= 1'b1;
              trig[c]            <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (last_tick) begin
              tick_cnt <= '0;
              if (row == LAST_ROW) begin
                phrase_done <= 1'b1;
                row         <= '0;
                if (!loop_en) begin
                  gate <= '0;
                end
              end else begin
                row <= row + ROW_W'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TCNT_W'(1);
            end
          end
        end
        default: begin
          row <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phrase_sequencer.sv
// Directed bench for phrase_sequencer with TICK_DIV=4.
module tb_phrase_sequencer;

  logic        clk = 1'b0;
  logic        rst_active_high;
  logic        play;
  logic        stop;
  logic        loop_en;
  logic [4:0]  speed;
  logic [3:0]  swing;
  logic [3:0]  row;
  logic [15:0] channel_0;
  logic [15:0] channel_1;
  logic [15:0] channel_2;
  logic [15:0] channel_3;
  logic [31:0] note_out;
  logic [23:0] vol_out;
  logic [7:0]  inst_out;
  logic [3:0]  gate;
  logic [3:0]  trig;
  logic        row_strobe;
  logic        playing;
  logic        phrase_done;

  logic [15:0] mem [16][4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign channel_0 = mem[row][0];
  assign channel_1 = mem[row][1];
  assign channel_2 = mem[row][2];
  assign channel_3 = mem[row][3];

  phrase_sequencer #(
    .TICK_DIV (4),
    .ROWS     (16)
  ) dut (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .play            (play),
    .stop            (stop),
    .loop_en         (loop_en),
    .speed           (speed),
`ifdef SEQ_SWING_EN
    .swing           (swing),
`endif
    .row             (row),
    .channel_0       (channel_0),
    .channel_1       (channel_1),
    .channel_2       (channel_2),
    .channel_3       (channel_3),
    .note_out        (note_out),
    .vol_out         (vol_out),
    .inst_out        (inst_out),
    .gate            (gate),
    .trig            (trig),
    .row_strobe      (row_strobe),
    .playing         (playing),
    .phrase_done     (phrase_done)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 4; c++) begin
        mem[r][c] = 16'h0000;
      end
    end
    mem[0][0] = 16'h3CF9;  // note 3C, vol 3E, inst 1
    mem[1][0] = 16'h0000;  // empty
    mem[2][0] = 16'hFF00;  // note-off
    mem[3][2] = 16'h4512;  // note 45, vol 04, inst 2

    rst_active_high = 1'b1;
    play    = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b1;
    speed   = 5'd2;
    swing   = 4'd0;

    // Reset
    step(2);
    chk("rst_row",      32'(row), 32'h0);
    chk("rst_note",     note_out, 32'h0);
    chk("rst_vol",      32'(vol_out), 32'h0);
    chk("rst_inst",     32'(inst_out), 32'h0);
    chk("rst_gate",     32'(gate), 32'h0);
    chk("rst_trig",     32'(trig), 32'h0);
    chk("rst_strobe",   32'(row_strobe), 32'h0);
    chk("rst_playing",  32'(playing), 32'h0);
    chk("rst_done",     32'(phrase_done), 32'h0);
    rst_active_high = 1'b0;
    step(1);

    // Basic playback, speed=2: play in cycle N
    play = 1'b1;
    step(1);  // N+1
    play = 1'b0;
    chk("fetch_row",     32'(row), 32'h0);
    chk("fetch_playing", 32'(playing), 32'h1);
    chk("fetch_trig",    32'(trig), 32'h0);
    step(1);  // N+2
    chk("r0_trig",   32'(trig), 32'h1);
    chk("r0_strobe", 32'(row_strobe), 32'h1);
    chk("r0_note",   note_out, 32'h0000003C);
    chk("r0_vol",    32'(vol_out), 32'h3E);
    chk("r0_inst",   32'(inst_out), 32'h1);
    chk("r0_gate",   32'(gate), 32'h1);
    step(1);  // N+3
    chk("r0_trig_pulse",   32'(trig), 32'h0);
    chk("r0_strobe_pulse", 32'(row_strobe), 32'h0);
    step(5);  // N+8
    chk("r0_hold_row", 32'(row), 32'h0);
    step(1);  // N+9
    chk("r1_row", 32'(row), 32'h1);
    step(1);  // N+10
    chk("r1_strobe", 32'(row_strobe), 32'h1);
    chk("r1_trig",   32'(trig), 32'h0);
    chk("r1_gate",   32'(gate), 32'h1);
    step(8);  // N+18
    chk("r2_row",  32'(row), 32'h2);
    chk("r2_gate", 32'(gate), 32'h0);
    chk("r2_trig", 32'(trig), 32'h0);
    chk("r2_note", note_out, 32'h0000003C);
    step(8);  // N+26
    chk("r3_trig", 32'(trig), 32'h4);
    chk("r3_note", note_out, 32'h0045003C);
    chk("r3_vol",  32'(vol_out), 32'h00403E);
    chk("r3_inst", 32'(inst_out), 32'h21);
    chk("r3_gate", 32'(gate), 32'h4);
    step(17); // N+43, HOLD at row 5
    chk("r5_row", 32'(row), 32'h5);

    // play and stop together: stop wins
    play = 1'b1;
    stop = 1'b1;
    step(1);
    play = 1'b0;
    stop = 1'b0;
    chk("ps_playing", 32'(playing), 32'h0);
    chk("ps_row",     32'(row), 32'h0);
    chk("ps_trig",    32'(trig), 32'h0);
    chk("ps_strobe",  32'(row_strobe), 32'h0);
    chk("ps_gate",    32'(gate), 32'h0);
    chk("ps_note",    note_out, 32'h0045003C);
    step(3);
    chk("ps_idle", 32'(playing), 32'h0);

    // speed=0 acts as 1 tick per row; play in cycle M
    speed = 5'd0;
    play  = 1'b1;
    step(1);  // M+1
    play = 1'b0;
    step(1);  // M+2
    chk("s0_trig", 32'(trig), 32'h1);
    step(2);  // M+4
    chk("s0_r0_row", 32'(row), 32'h0);
    step(1);  // M+5
    chk("s0_r1_row", 32'(row), 32'h1);
    step(12); // M+17
    chk("s0_r4_row", 32'(row), 32'h4);
    step(47); // M+64
    chk("lp_r15_row",  32'(row), 32'hF);
    chk("lp_r15_done", 32'(phrase_done), 32'h0);
    chk("lp_r15_gate", 32'(gate), 32'h4);
    step(1);  // M+65
    chk("lp_done",    32'(phrase_done), 32'h1);
    chk("lp_row",     32'(row), 32'h0);
    chk("lp_playing", 32'(playing), 32'h1);
    step(1);  // M+66
    chk("lp_done_pulse", 32'(phrase_done), 32'h0);
    chk("lp_strobe",     32'(row_strobe), 32'h1);
    chk("lp_trig",       32'(trig), 32'h1);
    loop_en = 1'b0;
    step(62); // M+128
    chk("end_r15_row",  32'(row), 32'hF);
    chk("end_r15_gate", 32'(gate), 32'h4);
    step(1);  // M+129
    chk("end_done",    32'(phrase_done), 32'h1);
    chk("end_playing", 32'(playing), 32'h0);
    chk("end_gate",    32'(gate), 32'h0);
    chk("end_row",     32'(row), 32'h0);
    step(1);  // M+130
    chk("end_done_pulse", 32'(phrase_done), 32'h0);
    chk("end_idle",       32'(playing), 32'h0);

    loop_en = 1'b1;
`ifdef SEQ_SWING_EN
    // speed=1, swing=2: even rows 12 cycles, odd rows 4; play in cycle S
    speed = 5'd1;
    swing = 4'd2;
    play  = 1'b1;
    step(1);  // S+1
    play = 1'b0;
    step(11); // S+12
    chk("sw_r0_row", 32'(row), 32'h0);
    step(1);  // S+13
    chk("sw_r1_row", 32'(row), 32'h1);
    step(3);  // S+16
    chk("sw_r1_hold", 32'(row), 32'h1);
    step(1);  // S+17
    chk("sw_r2_row", 32'(row), 32'h2);
`else
    // speed=3: every row 12 cycles; play in cycle S
    speed = 5'd3;
    play  = 1'b1;
    step(1);  // S+1
    play = 1'b0;
    step(11); // S+12
    chk("s3_r0_row", 32'(row), 32'h0);
    step(1);  // S+13
    chk("s3_r1_row", 32'(row), 32'h1);
    step(11); // S+24
    chk("s3_r1_hold", 32'(row), 32'h1);
    step(1);  // S+25
    chk("s3_r2_row", 32'(row), 32'h2);
`endif
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("final_stop", 32'(playing), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
